// File: rtl/cv32e40p_x_mac_pkg.sv
// Shared types for the custom-0 multiply/accumulate coprocessor: opcode default,
// funct3 encodings, pipeline entry and response records.
package cv32e40p_x_mac_pkg;

  localparam logic [6:0] OPCODE_DEFAULT = 7'h0B;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MAC    = 3'b001,
    F3_ACCRD  = 3'b010,
    F3_ACCCLR = 3'b011
  } funct3_e;

  typedef struct packed {
    logic        valid;
    funct3_e     op;
    logic [4:0]  rd;
    logic        wb;
    logic        err;
    logic [31:0] product;
  } pipe_entry_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        error;
  } resp_t;

endpackage

// File: rtl/cv32e40p_x_mac_resp_fifo.sv
// In-order response FIFO; head entry is visible on o_data, push and pop may
// coincide (including when full).
module cv32e40p_x_mac_resp_fifo
  import cv32e40p_x_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  i_push,
  input  resp_t i_data,
  input  logic  i_pop,
  output resp_t o_data,
  output logic  o_empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  resp_t         r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && ((r_cnt != FULL) || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + PW'(1);
      if (w_do_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_x_mac_copro.sv
// X-interface multiply/accumulate coprocessor: decode, fixed-latency multiply
// pipeline, accumulator and credit-throttled response FIFO. Optional macro
// X_MAC_SATURATE_EN makes the MAC add saturate as signed 32-bit.
module cv32e40p_x_mac_copro
  import cv32e40p_x_mac_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned RESP_DEPTH  = 2,
  parameter logic [6:0]  OPCODE      = OPCODE_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_q_valid_i,
  output logic             x_q_ready_o,
  input  logic [31:0]      x_q_instr_data_i,
  input  logic [2:0][31:0] x_q_rs_i,
  input  logic [2:0]       x_q_rs_valid_i,
  input  logic             x_q_rd_clean_i,
  output logic             x_k_accept_o,
  output logic             x_k_is_mem_op_o,
  output logic             x_k_writeback_o,
  output logic             x_p_valid_o,
  input  logic             x_p_ready_i,
  output logic [4:0]       x_p_rd_o,
  output logic [31:0]      x_p_data_o,
  output logic             x_p_dualwb_o,
  output logic             x_p_type_o,
  output logic             x_p_error_o,
  output logic             busy_o
);

  localparam int          LAT = int'(MUL_LATENCY);
  localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(RESP_DEPTH);

  function automatic logic [31:0] mac_add(input logic [31:0] a, input logic [31:0] b);
`ifdef X_MAC_SATURATE_EN
    logic signed [32:0] sum;
    sum = $signed({a[31], a}) + $signed({b[31], b});
    if (sum[32] != sum[31]) return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return sum[31:0];
`else
    return a + b;
`endif
  endfunction

  logic [2:0]    w_funct3;
  logic          w_match;
  logic          w_err;
  logic          w_wb;
  logic          w_rs_ok;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_pop;
  logic          w_push;
  logic          w_pipe_busy;
  logic          w_fifo_empty;
  logic [31:0]   w_mac_sum;
  logic [CW-1:0] r_credits;
  logic [31:0]   r_acc;
  pipe_entry_t   w_entry_p0;
  pipe_entry_t   w_exit;
  resp_t         w_push_resp;
  resp_t         w_head;
  logic          w_unused;

  assign w_unused = ^{x_q_rs_i[2], x_q_rs_valid_i[2], x_q_instr_data_i[31:15]};

  assign w_funct3    = x_q_instr_data_i[14:12];
  assign w_match     = (x_q_instr_data_i[6:0] == OPCODE);
  assign w_err       = w_funct3[2];
  assign w_wb        = w_err || (w_funct3 != 3'b011);
  // MUL/MAC (funct3 00x) are the only operations that read rs1/rs2
  assign w_rs_ok     = w_err || w_funct3[1] || (&x_q_rs_valid_i[1:0]);
  assign w_credit_ok = !w_wb || (x_q_rd_clean_i && (r_credits < CREDITS_MAX));

  assign x_q_ready_o     = rst_ni && (!w_match || (w_rs_ok && w_credit_ok));
  assign x_k_accept_o    = rst_ni && w_match;
  assign x_k_is_mem_op_o = 1'b0;
  assign x_k_writeback_o = w_match && w_wb;
  assign w_issue         = x_q_valid_i && x_q_ready_o && x_k_accept_o;

  // Stage p0: issue, product formed combinationally
  always_comb begin
    w_entry_p0         = '0;
    w_entry_p0.valid   = w_issue;
    w_entry_p0.op      = funct3_e'(w_funct3);
    w_entry_p0.rd      = x_q_instr_data_i[11:7];
    w_entry_p0.wb      = w_wb;
    w_entry_p0.err     = w_err;
    w_entry_p0.product = x_q_rs_i[0] * x_q_rs_i[1];
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign w_exit      = w_entry_p0;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      pipe_entry_t r_pipe_p1 [LAT-1];

      // Stages p1..p(L-1): fixed delay line, valid bits are the only reset state
      always_ff @(posedge clk_i) begin
        r_pipe_p1[0] <= w_entry_p0;
        for (int i = 1; i < LAT - 1; i++) r_pipe_p1[i] <= r_pipe_p1[i-1];
        if (!rst_ni) begin
          for (int i = 0; i < LAT - 1; i++) r_pipe_p1[i].valid <= 1'b0;
        end
      end

      always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < LAT - 1; i++) w_pipe_busy = w_pipe_busy | r_pipe_p1[i].valid;
      end

      assign w_exit = r_pipe_p1[LAT-2];
    end
  endgenerate

  // Exit stage: accumulator update and response push in program order
  assign w_mac_sum = mac_add(r_acc, w_exit.product);

  always_comb begin
    w_push            = w_exit.valid && w_exit.wb;
    w_push_resp.rd    = w_exit.rd;
    w_push_resp.error = w_exit.err;
    w_push_resp.data  = '0;
    if (!w_exit.err) begin
      case (w_exit.op)
        F3_MUL:   w_push_resp.data = w_exit.product;
        F3_MAC:   w_push_resp.data = w_mac_sum;
        F3_ACCRD: w_push_resp.data = r_acc;
        default:  w_push_resp.data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (w_exit.valid && !w_exit.err) begin
      if (w_exit.op == F3_MAC)         r_acc <= w_mac_sum;
      else if (w_exit.op == F3_ACCCLR) r_acc <= '0;
    end
  end

  // Credits bound outstanding writebacks so the FIFO can never overflow
  assign w_pop = x_p_valid_o && x_p_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_credits <= '0;
    end else begin
      case ({w_issue && w_wb, w_pop})
        2'b10:   r_credits <= r_credits + CW'(1);
        2'b01:   r_credits <= r_credits - CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  cv32e40p_x_mac_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_data  (w_push_resp),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty)
  );

  assign x_p_valid_o  = !w_fifo_empty;
  assign x_p_rd_o     = x_p_valid_o ? w_head.rd    : '0;
  assign x_p_data_o   = x_p_valid_o ? w_head.data  : '0;
  assign x_p_error_o  = x_p_valid_o ? w_head.error : 1'b0;
  assign x_p_dualwb_o = 1'b0;
  assign x_p_type_o   = 1'b0;
  assign busy_o       = w_pipe_busy || x_p_valid_o;

endmodule

// File: tb/tb_cv32e40p_x_mac_copro.sv
// Bench for cv32e40p_x_mac_copro: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_cv32e40p_x_mac_copro;

  localparam int L = 2;
  localparam int D = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             x_q_valid_i = 1'b0;
  logic             x_q_ready_o;
  logic [31:0]      x_q_instr_data_i = '0;
  logic [2:0][31:0] x_q_rs_i = '0;
  logic [2:0]       x_q_rs_valid_i = '0;
  logic             x_q_rd_clean_i = 1'b1;
  logic             x_k_accept_o;
  logic             x_k_is_mem_op_o;
  logic             x_k_writeback_o;
  logic             x_p_valid_o;
  logic             x_p_ready_i = 1'b1;
  logic [4:0]       x_p_rd_o;
  logic [31:0]      x_p_data_o;
  logic             x_p_dualwb_o;
  logic             x_p_type_o;
  logic             x_p_error_o;
  logic             busy_o;

  cv32e40p_x_mac_copro #(.MUL_LATENCY(L), .RESP_DEPTH(D), .OPCODE(7'h0B)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_q_valid_i(x_q_valid_i), .x_q_ready_o(x_q_ready_o),
    .x_q_instr_data_i(x_q_instr_data_i), .x_q_rs_i(x_q_rs_i),
    .x_q_rs_valid_i(x_q_rs_valid_i), .x_q_rd_clean_i(x_q_rd_clean_i),
    .x_k_accept_o(x_k_accept_o), .x_k_is_mem_op_o(x_k_is_mem_op_o),
    .x_k_writeback_o(x_k_writeback_o),
    .x_p_valid_o(x_p_valid_o), .x_p_ready_i(x_p_ready_i),
    .x_p_rd_o(x_p_rd_o), .x_p_data_o(x_p_data_o),
    .x_p_dualwb_o(x_p_dualwb_o), .x_p_type_o(x_p_type_o),
    .x_p_error_o(x_p_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    int          rdy_cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped_data[$];
  logic        popped_err[$];
  logic [31:0] acc_m = '0;
  int          cyc = 0;
  int          credits = 0;
  int          last_pop = -100;
  int          last_issue = -100;
  bit          post_rst = 0;
  bit          rand_mode = 0;

  // model-side scratch for the monitor
  bit          m_match, m_needs, m_wb, m_err, m_rdy, m_valid, m_busy;
  logic [2:0]  m_f3;
  logic [31:0] m_prod, m_data;
  longint      m_sum;
  exp_t        m_e;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      check_eq("rst_q_ready", x_q_ready_o, 0);
      check_eq("rst_accept", x_k_accept_o, 0);
      q.delete();
      credits = 0; acc_m = '0; post_rst = 1;
      last_pop = -100; last_issue = -100;
    end else begin
      if (post_rst) begin
        check_eq("post_rst_rd", x_p_rd_o, 0);
        check_eq("post_rst_data", x_p_data_o, 0);
        check_eq("post_rst_err", x_p_error_o, 0);
        post_rst = 0;
      end
      m_valid = (q.size() > 0) && (cyc >= q[0].rdy_cyc) && (cyc > last_pop);
      m_busy  = (q.size() > 0) || ((cyc > last_issue) && (cyc < last_issue + L));
      check_eq("p_valid", x_p_valid_o, m_valid);
      check_eq("busy", busy_o, m_busy);
      check_eq("p_const0", {x_p_dualwb_o, x_p_type_o}, 0);
      if (m_valid && x_p_valid_o) begin
        check_eq("p_rd", x_p_rd_o, q[0].rd);
        check_eq("p_data", x_p_data_o, q[0].data);
        check_eq("p_err", x_p_error_o, q[0].err);
      end

      if (x_q_valid_i) begin
        m_f3    = x_q_instr_data_i[14:12];
        m_match = (x_q_instr_data_i[6:0] == 7'h0B);
        m_err   = (m_f3 >= 3'd4);
        m_needs = (m_f3 == 3'd0) || (m_f3 == 3'd1);
        m_wb    = (m_f3 != 3'd3);
        m_rdy   = !m_match ||
                  ((!m_needs || (x_q_rs_valid_i[0] && x_q_rs_valid_i[1])) &&
                   (!m_wb || (x_q_rd_clean_i && credits < D)));
        check_eq("q_ready", x_q_ready_o, m_rdy);
        check_eq("k_accept", x_k_accept_o, m_match);
        check_eq("k_wb", x_k_writeback_o, m_match && m_wb);
        check_eq("k_memop", x_k_is_mem_op_o, 0);
        if (m_match && m_rdy) begin
          m_prod = 32'(({32'b0, x_q_rs_i[0]} * {32'b0, x_q_rs_i[1]}) & 64'hFFFF_FFFF);
          m_data = '0;
          if (!m_err) begin
            case (m_f3)
              3'd0: m_data = m_prod;
              3'd1: begin
`ifdef X_MAC_SATURATE_EN
                m_sum = longint'(int'(acc_m)) + longint'(int'(m_prod));
                if (m_sum > 64'sd2147483647)       acc_m = 32'h7FFF_FFFF;
                else if (m_sum < -64'sd2147483648) acc_m = 32'h8000_0000;
                else                               acc_m = 32'(m_sum);
`else
                acc_m = acc_m + m_prod;
`endif
                m_data = acc_m;
              end
              3'd2: m_data = acc_m;
              default: acc_m = '0;
            endcase
          end
          if (m_wb) begin
            m_e.rd = x_q_instr_data_i[11:7]; m_e.data = m_data;
            m_e.err = m_err; m_e.rdy_cyc = cyc + L;
            q.push_back(m_e);
            credits++;
          end
          last_issue = cyc;
        end
      end

      if (m_valid && x_p_ready_i) begin
        popped_data.push_back(x_p_data_o);
        popped_err.push_back(x_p_error_o);
        void'(q.pop_front());
        credits--;
        last_pop = cyc;
      end
    end
  end

  always @(posedge clk_i) begin
    if (rand_mode) begin
      #1;
      x_p_ready_i    = ($urandom_range(0, 3) != 0);
      x_q_rd_clean_i = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, 7'h0B};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] rsv);
    x_q_valid_i = 1'b1; x_q_instr_data_i = instr;
    x_q_rs_i[0] = a; x_q_rs_i[1] = b; x_q_rs_i[2] = $urandom();
    x_q_rs_valid_i = rsv;
  endtask

  task automatic wait_issue(input int max, output int n);
    n = 0;
    forever begin
      @(negedge clk_i);
      if (x_q_ready_o) break;
      n++;
      if (n >= max) begin
        check_eq("handshake_timeout", n, 0);
        break;
      end
    end
    @(posedge clk_i); #1;
    x_q_valid_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    int n;
    drive(instr, a, b, 3'b011);
    wait_issue(50, n);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_eq("drain_timeout", (q.size() == 0), 1);
    repeat (L + 1) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: return {28'h0, r[3:0]};
      1: return 32'h7FFF_FFF0 + {28'h0, r[3:0]};
      2: return 32'h8000_0000 + {28'h0, r[3:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] r, a, b, instr;
    logic [2:0] f3, rsv;
    logic [2:0] f3_tab [7];
    f3_tab = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // MUL 7*6 -> rd 5
    popped_data.delete();
    send(enc(3'd0, 5'd5), 32'd7, 32'd6);
    drain();
    check_eq("mul_count", popped_data.size(), 1);
    if (popped_data.size() == 1) check_eq("mul_data", popped_data[0], 32'd42);

    // ACCCLR; MAC(3,4); MAC(2,5); ACCRD
    popped_data.delete();
    send(enc(3'd3, 5'd1), 32'd0, 32'd0);
    send(enc(3'd1, 5'd2), 32'd3, 32'd4);
    send(enc(3'd1, 5'd3), 32'd2, 32'd5);
    send(enc(3'd2, 5'd9), 32'd0, 32'd0);
    drain();
    check_eq("acc_count", popped_data.size(), 3);
    if (popped_data.size() == 3) begin
      check_eq("acc_mac1", popped_data[0], 32'd12);
      check_eq("acc_mac2", popped_data[1], 32'd22);
      check_eq("acc_rd", popped_data[2], 32'd22);
    end

    // overflow boundary
    popped_data.delete();
    send(enc(3'd3, 5'd1), 32'd0, 32'd0);
    send(enc(3'd1, 5'd2), 32'd1, 32'd1);
    send(enc(3'd1, 5'd3), 32'h7FFF_FFFF, 32'd1);
    drain();
    check_eq("ovf_count", popped_data.size(), 2);
    if (popped_data.size() == 2) begin
`ifdef X_MAC_SATURATE_EN
      check_eq("ovf_data", popped_data[1], 32'h7FFF_FFFF);
`else
      check_eq("ovf_data", popped_data[1], 32'h8000_0000);
`endif
    end

    // credit backpressure: third MUL waits for the first pop
    x_p_ready_i = 1'b0;
    send(enc(3'd0, 5'd10), 32'd3, 32'd3);
    send(enc(3'd0, 5'd11), 32'd4, 32'd4);
    drive(enc(3'd0, 5'd12), 32'd5, 32'd5, 3'b011);
    repeat (5) @(posedge clk_i);
    #1 x_p_ready_i = 1'b1;
    wait_issue(20, n);
    drain();

    // foreign opcode, missing operand, operand-free ACCRD
    popped_data.delete();
    drive({17'h0, 3'd0, 5'd4, 7'h33}, 32'd1, 32'd1, 3'b011);
    wait_issue(5, n);
    check_eq("reject_wait", n, 0);
    drive(enc(3'd0, 5'd6), 32'd9, 32'd9, 3'b001);
    repeat (3) @(posedge clk_i);
    #1 x_q_rs_valid_i = 3'b011;
    wait_issue(5, n);
    drive(enc(3'd2, 5'd7), 32'd0, 32'd0, 3'b000);
    wait_issue(5, n);
    check_eq("accrd_wait", n, 0);
    drain();
    check_eq("misc_count", popped_data.size(), 2);
    if (popped_data.size() == 2) check_eq("misc_mul", popped_data[0], 32'd81);

    // illegal funct3
    popped_data.delete(); popped_err.delete();
    send(enc(3'd7, 5'd4), 32'd5, 32'd5);
    drain();
    check_eq("err_count", popped_data.size(), 1);
    if (popped_data.size() == 1) begin
      check_eq("err_data", popped_data[0], 32'd0);
      check_eq("err_flag", popped_err[0], 1'b1);
    end

    // reset with responses pending
    send(enc(3'd1, 5'd1), 32'd5, 32'd5);
    drain();
    x_p_ready_i = 1'b0;
    send(enc(3'd0, 5'd2), 32'd2, 32'd2);
    send(enc(3'd0, 5'd3), 32'd3, 32'd2);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    x_q_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1; x_q_valid_i = 1'b0; x_p_ready_i = 1'b1;
    popped_data.delete();
    send(enc(3'd2, 5'd8), 32'd0, 32'd0);
    drain();
    check_eq("rst_count", popped_data.size(), 1);
    if (popped_data.size() == 1) check_eq("rst_accrd", popped_data[0], 32'd0);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom();
      f3 = f3_tab[$urandom_range(0, 6)];
      a = pick(); b = pick();
      instr = {r[31:15], f3, r[11:7], (r[3:0] == 4'h0) ? 7'h33 : 7'h0B};
      rsv = 3'($urandom_range(0, 7));
      if ((f3 <= 3'd1) && (rsv[1:0] != 2'b11)) begin
        drive(instr, a, b, rsv);
        repeat (2) @(posedge clk_i);
        #1 x_q_rs_valid_i = rsv | 3'b011;
      end else begin
        drive(instr, a, b, rsv);
      end
      wait_issue(80, n);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    rand_mode = 0;
    @(posedge clk_i); #1;
    x_p_ready_i = 1'b1; x_q_rd_clean_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
